// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte-stream requesters, the arbiter and one uart_tx.
// master drives requests and uart busy; slave is the arbiter side.
interface uart_tx_arbiter_if #(
    parameter int unsigned N_REQ = 2
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] data;
    logic [N_REQ-1:0]   last;
    logic [N_REQ-1:0]   ack;
    logic               grant_valid;
    logic [2:0]         grant_id;
    logic [7:0]         tx_data;
    logic               tx_start;
    logic               tx_busy;
    logic               timeout;

    modport master (
        output req, data, last, tx_busy,
        input  ack, grant_valid, grant_id, tx_data, tx_start, timeout
    );

    modport slave (
        input  req, data, last, tx_busy,
        output ack, grant_valid, grant_id, tx_data, tx_start, timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-locked arbiter sharing one uart_tx between N_REQ byte streams.
// A holder keeps the transmitter until a byte tagged last completes or it stalls too long.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ       = 2,
    parameter int unsigned HOLD_CYCLES = 1200
) (
    input logic              clk,
    input logic              reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned IdW   = $clog2(N_REQ);
    localparam int unsigned HoldW = $clog2(HOLD_CYCLES);

    typedef enum logic [1:0] {StIdle, StSend, StWaitBusy, StWaitDone} state_e;

    state_e             state_q, state_d;
    logic [IdW-1:0]     grant_q, grant_d;
    logic [IdW-1:0]     last_winner_q, last_winner_d;
    logic               grant_valid_q, grant_valid_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               frame_last_q, frame_last_d;
    logic               tx_start_q, tx_start_d;
    logic               timeout_q, timeout_d;
    logic [N_REQ-1:0]   ack_q, ack_d;

    logic [7:0]         data_arr [N_REQ];
    logic [IdW-1:0]     cand;
    logic [IdW-1:0]     pick_id;
    logic               pick_valid;

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            data_arr[i] = bus.data[8*i +: 8];
        end
    end

    // Search starts one past the previous winner and wraps around.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = IdW'((32'(last_winner_q) + i) % N_REQ);
            if (!pick_valid && bus.req[cand]) begin
                pick_valid = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_winner_d = last_winner_q;
        grant_valid_d = grant_valid_q;
        hold_d        = hold_q;
        tx_data_d     = tx_data_q;
        frame_last_d  = frame_last_q;
        tx_start_d    = 1'b0;
        timeout_d     = 1'b0;
        ack_d         = '0;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    grant_d       = pick_id;
                    grant_valid_d = 1'b1;
                    hold_d        = '0;
                    state_d       = StSend;
                end
            end
            StSend: begin
                if (bus.req[grant_q]) begin
                    // A busy transmitter is not a requester stall, so the hold count is frozen.
                    if (!bus.tx_busy) begin
                        tx_data_d      = data_arr[grant_q];
                        frame_last_d   = bus.last[grant_q];
                        tx_start_d     = 1'b1;
                        ack_d[grant_q] = 1'b1;
                        hold_d         = '0;
                        state_d        = StWaitBusy;
                    end
                end else if (hold_q == HoldW'(HOLD_CYCLES - 2)) begin
                    timeout_d     = 1'b1;
                    grant_valid_d = 1'b0;
                    last_winner_d = grant_q;
                    hold_d        = '0;
                    state_d       = StIdle;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StWaitBusy: begin
                if (bus.tx_busy) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (!bus.tx_busy) begin
                    if (frame_last_q) begin
                        grant_valid_d = 1'b0;
                        last_winner_d = grant_q;
                        state_d       = StIdle;
                    end else begin
                        state_d = StSend;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            grant_q       <= '0;
            last_winner_q <= IdW'(N_REQ - 1);
            grant_valid_q <= 1'b0;
            hold_q        <= '0;
            tx_data_q     <= '0;
            frame_last_q  <= 1'b0;
            tx_start_q    <= 1'b0;
            timeout_q     <= 1'b0;
            ack_q         <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_winner_q <= last_winner_d;
            grant_valid_q <= grant_valid_d;
            hold_q        <= hold_d;
            tx_data_q     <= tx_data_d;
            frame_last_q  <= frame_last_d;
            tx_start_q    <= tx_start_d;
            timeout_q     <= timeout_d;
            ack_q         <= ack_d;
        end
    end

    assign bus.ack         = ack_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_id    = 3'(grant_q);
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.timeout     = timeout_q;
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx instance between N_REQ byte-stream requesters.
- Grants are round-robin and frame-locked: a granted requester keeps the transmitter until it sends a byte tagged last, or until it stalls longer than HOLD_CYCLES.
- Sits between message sources (ROM sequencers, rx echo path, status reporters) and uart_tx. Drives uart_tx start/data and watches its busy output.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- HOLD_CYCLES, 1200, max idle cycles a locked requester may stall mid-frame before its grant is revoked (100 us at 12 MHz). Must be >=2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester byte valid; level, held until ack.
- data  in  8*N_REQ  flattened bytes; requester i occupies bits [8i+7:8i].
- last  in  N_REQ  per-requester end-of-frame tag; qualified with req.
- ack  out  N_REQ  one-cycle pulse: byte of requester i accepted.
- grant_valid  out  1  a requester currently holds the transmitter.
- grant_id  out  3  index of the holder; valid only when grant_valid=1.
- tx_data  out  8  byte to uart_tx.data.
- tx_start  out  1  one-cycle start pulse to uart_tx.start.
- tx_busy  in  1  uart_tx.busy.
- timeout  out  1  one-cycle pulse when a stalled grant is revoked.

Behaviour:
- All outputs registered. Reset (async assert, sync release) forces:
  - ack=0, tx_start=0, timeout=0, grant_valid=0, grant_id=0, tx_data=0, state IDLE, hold counter 0.
  - rr pointer set so requester 0 has top priority after reset (last_winner=N_REQ-1).
  - Reset mid-frame aborts the frame. No ack is issued for the byte in flight.
- States: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any req bit is set, select the first set bit searching from (last_winner+1) mod N_REQ upward with wrap.
  - Register grant_id and set grant_valid=1. Go to SEND.
  - Req bits arriving later are ignored until the next IDLE.
- SEND, when req[grant_id]=1 and tx_busy=0:
  - Latch tx_data=data[grant_id] and the frame flag from last[grant_id].
  - Pulse tx_start=1 and ack[grant_id]=1 for exactly one cycle, starting the next cycle.
  - Clear the hold counter. Go to WAIT_BUSY.
- SEND, when req[grant_id]=0:
  - Increment the hold counter.
  - When it reaches HOLD_CYCLES-1: pulse timeout, clear grant_valid, set last_winner=grant_id, go to IDLE.
- SEND, when req[grant_id]=1 and tx_busy=1: wait; the hold counter does not increment.
- WAIT_BUSY: stay until tx_busy=1, then go to WAIT_DONE. tx_start is not reissued.
- WAIT_DONE: stay until tx_busy=0.
  - If the latched last=1: clear grant_valid, set last_winner=grant_id, go to IDLE.
  - Otherwise return to SEND.
- Latency: req rising in IDLE at cycle 0 -> grant_valid at cycle 1 -> tx_start and ack at cycle 2.
  - Minimum gap between back-to-back bytes of one frame equals the uart_tx frame time plus 2 cycles.
- Only one ack bit may be high in any cycle. tx_start and the ack bit are always coincident.
- Data rules:
  - Requesters must hold data and last stable while req=1 and ack=0.
  - After ack, the requester may change data in the ack cycle itself.
- Single requester:
  - Round-robin degenerates to repeated grant of that requester.
  - The IDLE->SEND transition still costs one cycle per frame.
- grant_id is zero-extended. Widths beyond log2(N_REQ) read 0.

Test Plan:
- Single frame, N_REQ=3: req[1] sends 0x48, 0x65 with last on the 2nd byte; tx_busy model is 10 cycles per byte.
  - Expect grant_id=1, two tx_start pulses carrying 0x48 and 0x65, ack[1] pulses aligned with them, grant_valid drop after the 2nd busy fall.
- Round-robin: req[0] and req[2] assert simultaneously, each sending a one-byte frame, with req[0] re-asserting immediately.
  - Expect order 0, 2, 0. Requester 0 is served first after reset.
- Frame lock: req[0] frame of 3 bytes; req[1] asserts during byte 1.
  - Expect all 3 bytes of requester 0 to go out before grant_id=1.
  - ack[1] must stay low until requester 0's last byte completes.
- Stall timeout: HOLD_CYCLES=8; req[2] sends one non-last byte, then drops req.
  - Expect a timeout pulse exactly 7 cycles after entering SEND with req low, grant_valid=0, then requester 0 granted if pending.
- Async reset mid-byte: assert reset while in WAIT_DONE.
  - Expect all outputs 0 immediately without a clock edge.
  - After release with req[1] and req[0] both high, requester 0 is granted first.
- Busy backpressure: hold tx_busy=1 for 20 cycles entering SEND with req high.
  - Expect no tx_start, no timeout, and start issued the cycle after busy falls.
